// File: rtl/in_pkt_fifo_if.sv
// Purpose: bundles the application-side byte port, the SIE-side byte port and
//          the SIE transaction controls of the IN packet FIFO.
// Latency: n/a (wiring only).
// Backpressure: app_in_ready_o throttles the application; in_ready_i throttles the SIE read.
// Ports (slave = FIFO side):
//   app_in_data_i/app_in_valid_i/app_in_ready_o  application byte handshake
//   app_flush_i                                  discard buffered bytes
//   in_empty_o/in_full_o/in_level_o              committed occupancy
//   in_data_o/in_valid_o                         byte towards the SIE
//   in_req_i/in_ready_i/in_data_ack_i/out_valid_i/out_ready_i  SIE transaction controls
interface in_pkt_fifo_if #(
  parameter int LEVEL_W = 5
);
  logic [7:0]         app_in_data_i;
  logic               app_in_valid_i;
  logic               app_in_ready_o;
  logic               app_flush_i;
  logic               in_empty_o;
  logic               in_full_o;
  logic [LEVEL_W-1:0] in_level_o;
  logic [7:0]         in_data_o;
  logic               in_valid_o;
  logic               in_req_i;
  logic               in_ready_i;
  logic               in_data_ack_i;
  logic               out_valid_i;
  logic               out_ready_i;

  modport slave (
    input  app_in_data_i, app_in_valid_i, app_flush_i,
    input  in_req_i, in_ready_i, in_data_ack_i, out_valid_i, out_ready_i,
    output app_in_ready_o, in_empty_o, in_full_o, in_level_o, in_data_o, in_valid_o
  );

  modport master (
    output app_in_data_i, app_in_valid_i, app_flush_i,
    output in_req_i, in_ready_i, in_data_ack_i, out_valid_i, out_ready_i,
    input  app_in_ready_o, in_empty_o, in_full_o, in_level_o, in_data_o, in_valid_o
  );
endinterface

// File: rtl/in_pkt_fifo.sv
// Purpose: IN endpoint byte FIFO with speculative packet reads, commit on ACK and retransmit otherwise.
// Latency: a written byte is readable by the next transaction; in_valid_o follows the read pointer combinationally.
// Backpressure: app writes paced to one per BIT_SAMPLES cycles and stalled while full or flushing; SIE reads stall on in_ready_i.
// Ports: clk_i, rstn_i (async active-low), bus (in_pkt_fifo_if.slave, see interface header).
module in_pkt_fifo #(
  parameter int IN_MAXPACKETSIZE = 8,
  parameter int IN_BUFFER_SIZE   = 16,
  parameter int BIT_SAMPLES      = 4,
  parameter int ZLP_EN           = 1
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  in_pkt_fifo_if.slave bus
);

  localparam int PTR_W  = (IN_BUFFER_SIZE > 1) ? $clog2(IN_BUFFER_SIZE) : 1;
  localparam int LVL_W  = $clog2(IN_BUFFER_SIZE + 1);
  localparam int SENT_W = $clog2(IN_MAXPACKETSIZE + 1);
  localparam int PACE_W = (BIT_SAMPLES > 1) ? $clog2(BIT_SAMPLES) : 1;

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(IN_BUFFER_SIZE - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(IN_BUFFER_SIZE);
  localparam logic [SENT_W-1:0] SENT_MAX  = SENT_W'(IN_MAXPACKETSIZE);
  localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(BIT_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, WAIT_ACK} state_t;

  state_t             state_q, state_d;
  logic [7:0]         buf_q [IN_BUFFER_SIZE];
  logic [PTR_W-1:0]   first_q, rd_q, last_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [SENT_W-1:0]  sent_q;
  logic [PACE_W-1:0]  pace_q;
  logic               zlp_pend_q, flush_pend_q, req_q;

  logic req_rise, commit, start, flush_now, wr_en, app_rdy, in_vld, rd_adv, unsent;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign req_rise = bus.in_req_i & ~req_q;
  assign commit   = (state_q == WAIT_ACK) & bus.out_ready_i & bus.in_data_ack_i;
  assign start    = (state_q != DATA) & (state_d == DATA);

  // A flush requested mid-transaction waits for the return to IDLE so that an
  // ACK arriving in the same cycle still commits before everything is dropped.
  assign flush_now = ((state_q == IDLE) & bus.app_flush_i) |
                     ((state_q != IDLE) & (state_d == IDLE) & (flush_pend_q | bus.app_flush_i));

  // rstn_i gating keeps ready low during reset even when the pacing counter
  // already sits at its terminal value (BIT_SAMPLES == 1).
  assign app_rdy = rstn_i & (level_q != LVL_FULL) & ~bus.app_flush_i & ~flush_now &
                   (pace_q == PACE_LAST);
  assign wr_en   = bus.app_in_valid_i & app_rdy;

  // Bytes written but not yet speculatively read. Same as rd_q != last_q,
  // except it also holds for a completely full buffer where the pointers meet.
  assign unsent  = (level_q != LVL_W'(sent_q));
  assign rd_adv  = in_vld & bus.in_ready_i;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (req_rise) state_d = DATA;
      DATA:     if (!bus.in_req_i) state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (commit)                                state_d = IDLE;
        else if (req_rise)                         state_d = DATA;
        else if (bus.out_valid_i | bus.out_ready_i) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_vld = 1'b0;
    if (state_q == DATA)
      in_vld = unsent & (sent_q < SENT_MAX) & ~zlp_pend_q;
  end

  always_comb begin
    level_d = level_q;
    if (wr_en)     level_d = level_d + LVL_W'(1);
    if (commit)    level_d = level_d - LVL_W'(sent_q);
    if (flush_now) level_d = '0;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < IN_BUFFER_SIZE; i++) buf_q[i] <= '0;
      first_q      <= '0;
      rd_q         <= '0;
      last_q       <= '0;
      level_q      <= '0;
      sent_q       <= '0;
      pace_q       <= '0;
      zlp_pend_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      req_q   <= bus.in_req_i;
      level_q <= level_d;

      if (wr_en) begin
        buf_q[last_q] <= bus.app_in_data_i;
        last_q        <= ptr_inc(last_q);
        pace_q        <= '0;
      end else if (pace_q != PACE_LAST) begin
        pace_q <= pace_q + PACE_W'(1);
      end

      // Every transaction, including a retry, restarts from the committed pointer.
      if (start) begin
        rd_q   <= first_q;
        sent_q <= '0;
      end else if (rd_adv) begin
        rd_q   <= ptr_inc(rd_q);
        sent_q <= sent_q + SENT_W'(1);
      end

      if (commit) first_q <= rd_q;

      // A full-size packet that drains the buffer must be followed by a ZLP
      // so the host sees the end of the transfer.
      if ((ZLP_EN != 0) && commit) begin
        if ((sent_q == SENT_MAX) && (level_d == '0)) zlp_pend_q <= 1'b1;
        else if (sent_q == '0)                       zlp_pend_q <= 1'b0;
      end

      if (flush_now)                                    flush_pend_q <= 1'b0;
      else if (bus.app_flush_i && (state_q != IDLE))    flush_pend_q <= 1'b1;

      // Flush overrides commit and transaction start bookkeeping.
      if (flush_now) begin
        first_q    <= last_q;
        rd_q       <= last_q;
        zlp_pend_q <= 1'b0;
      end
    end
  end

  assign bus.app_in_ready_o = app_rdy;
  assign bus.in_empty_o     = (level_q == '0);
  assign bus.in_full_o      = (level_q == LVL_FULL);
  assign bus.in_level_o     = level_q;
  assign bus.in_valid_o     = in_vld;
  assign bus.in_data_o      = buf_q[rd_q];

endmodule

// File: tb/tb_in_pkt_fifo.sv
// Purpose: directed self-checking bench for in_pkt_fifo (default 16-byte and 12-byte buffer instances).
// Latency: n/a.
// Backpressure: app writes wait (bounded) on app_in_ready_o of the selected instance.
module tb_in_pkt_fifo;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rstn_i;

  in_pkt_fifo_if #(.LEVEL_W(5)) bus0 ();
  in_pkt_fifo_if #(.LEVEL_W(4)) bus1 ();

  in_pkt_fifo dut0 (.clk_i(clk_i), .rstn_i(rstn_i), .bus(bus0));
  in_pkt_fifo #(.IN_BUFFER_SIZE(12)) dut1 (.clk_i(clk_i), .rstn_i(rstn_i), .bus(bus1));

  // Shared stimulus drives both instances; sel picks which one is observed.
  logic [7:0] app_data;
  logic app_valid, app_flush, in_req, in_ready, in_ack, out_valid, out_ready;
  logic sel;

  assign bus0.app_in_data_i = app_data;   assign bus1.app_in_data_i = app_data;
  assign bus0.app_in_valid_i = app_valid; assign bus1.app_in_valid_i = app_valid;
  assign bus0.app_flush_i = app_flush;    assign bus1.app_flush_i = app_flush;
  assign bus0.in_req_i = in_req;          assign bus1.in_req_i = in_req;
  assign bus0.in_ready_i = in_ready;      assign bus1.in_ready_i = in_ready;
  assign bus0.in_data_ack_i = in_ack;     assign bus1.in_data_ack_i = in_ack;
  assign bus0.out_valid_i = out_valid;    assign bus1.out_valid_i = out_valid;
  assign bus0.out_ready_i = out_ready;    assign bus1.out_ready_i = out_ready;

  logic       o_rdy, o_empty, o_full, o_vld;
  logic [7:0] o_lvl, o_dat;
  assign o_rdy   = sel ? bus1.app_in_ready_o : bus0.app_in_ready_o;
  assign o_empty = sel ? bus1.in_empty_o : bus0.in_empty_o;
  assign o_full  = sel ? bus1.in_full_o : bus0.in_full_o;
  assign o_vld   = sel ? bus1.in_valid_o : bus0.in_valid_o;
  assign o_dat   = sel ? bus1.in_data_o : bus0.in_data_o;
  assign o_lvl   = sel ? 8'(bus1.in_level_o) : 8'(bus0.in_level_o);

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic app_write(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk_i);
    app_data = b;
    app_valid = 1'b1;
    #1;
    while (!o_rdy && t < 200) begin
      @(negedge clk_i);
      #1;
      t++;
    end
    if (t >= 200) check("wr_timeout", {31'd0, o_rdy}, 1);
    @(posedge clk_i);
    #1;
    app_valid = 1'b0;
  endtask

  // One SIE transaction: request, read with ready every cycle, then end it with
  // an ACK (mode 0) or an out_valid token (mode 1).
  task automatic do_txn(input logic [7:0] exp[$], input int mode, input int lvl_wait, input string tag);
    logic [7:0] got[$];
    logic v_last;
    int cap;
    cap = sel ? 12 : 16;
    v_last = 1'b0;
    @(negedge clk_i);
    in_req = 1'b1;
    in_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      #1;
      v_last = o_vld;
      if (o_vld) got.push_back(o_dat);
    end
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check({tag, "_byte"}, {24'd0, got[i]}, {24'd0, exp[i]});
    check({tag, "_vld_end"}, {31'd0, v_last}, 0);
    in_req = 1'b0;
    in_ready = 1'b0;
    @(negedge clk_i);
    #1;
    check({tag, "_lvl_wait"}, {24'd0, o_lvl}, lvl_wait);
    check({tag, "_full_wait"}, {31'd0, o_full}, (lvl_wait == cap) ? 1 : 0);
    out_ready = (mode == 0);
    in_ack    = (mode == 0);
    out_valid = (mode == 1);
    @(negedge clk_i);
    out_ready = 1'b0;
    in_ack = 1'b0;
    out_valid = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] qe[$];
    logic [7:0] mq[$];
    logic [7:0] seqb;
    int zlp, n, sent;

    sel = 1'b0; app_data = '0; app_valid = 0; app_flush = 0;
    in_req = 0; in_ready = 0; in_ack = 0; out_valid = 0; out_ready = 0;
    rstn_i = 1'b0;
    #12;
    check("rst_vld", {31'd0, o_vld}, 0);
    check("rst_rdy", {31'd0, o_rdy}, 0);
    check("rst_empty", {31'd0, o_empty}, 1);
    check("rst_full", {31'd0, o_full}, 0);
    check("rst_lvl", {24'd0, o_lvl}, 0);
    check("rst_dat", {24'd0, o_dat}, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Three bytes, one ACKed packet.
    app_write(8'hA1); app_write(8'hA2); app_write(8'hA3);
    @(negedge clk_i); #1;
    check("t031_lvl3", {24'd0, o_lvl}, 3);
    check("t031_notempty", {31'd0, o_empty}, 0);
    q = {8'hA1, 8'hA2, 8'hA3};
    do_txn(q, 0, 3, "t031");
    check("t031_lvl0", {24'd0, o_lvl}, 0);
    check("t031_empty", {31'd0, o_empty}, 1);

    // 20 bytes through a 16-byte buffer: packets 8, 8, 4.
    for (int i = 0; i < 16; i++) app_write(8'h10 + 8'(i));
    repeat (5) @(negedge clk_i);
    #1;
    check("t032_full", {31'd0, o_full}, 1);
    check("t032_lvl16", {24'd0, o_lvl}, 16);
    check("t032_rdy_full", {31'd0, o_rdy}, 0);
    q.delete(); for (int i = 0; i < 8; i++) q.push_back(8'h10 + 8'(i));
    do_txn(q, 0, 16, "t032a");
    check("t032_lvl8", {24'd0, o_lvl}, 8);
    check("t032_notfull", {31'd0, o_full}, 0);
    for (int i = 16; i < 20; i++) app_write(8'h10 + 8'(i));
    q.delete(); for (int i = 8; i < 16; i++) q.push_back(8'h10 + 8'(i));
    do_txn(q, 0, 12, "t032b");
    q.delete(); for (int i = 16; i < 20; i++) q.push_back(8'h10 + 8'(i));
    do_txn(q, 0, 4, "t032c");
    check("t032_lvl0", {24'd0, o_lvl}, 0);

    // Unacknowledged packet is resent.
    q.delete(); for (int i = 0; i < 5; i++) begin app_write(8'h30 + 8'(i)); q.push_back(8'h30 + 8'(i)); end
    do_txn(q, 1, 5, "t033a");
    check("t033_lvl5", {24'd0, o_lvl}, 5);
    do_txn(q, 0, 5, "t033b");
    check("t033_lvl0", {24'd0, o_lvl}, 0);

    // Full-size packet draining the buffer forces a ZLP next.
    q.delete(); for (int i = 0; i < 8; i++) begin app_write(8'h40 + 8'(i)); q.push_back(8'h40 + 8'(i)); end
    do_txn(q, 0, 8, "t034a");
    check("t034_empty", {31'd0, o_empty}, 1);
    app_write(8'h48); app_write(8'h49);
    qe.delete();
    do_txn(qe, 0, 2, "t034zlp");
    check("t034_lvl2", {24'd0, o_lvl}, 2);
    q = {8'h48, 8'h49};
    do_txn(q, 0, 2, "t034b");
    check("t034_lvl0", {24'd0, o_lvl}, 0);

    // Flush during DATA is deferred to the end of the transaction.
    for (int i = 0; i < 6; i++) app_write(8'h50 + 8'(i));
    @(negedge clk_i);
    in_req = 1'b1; in_ready = 1'b1;
    @(negedge clk_i); #1;
    check("t035_b0", {24'd0, o_dat}, 8'h50);
    @(negedge clk_i); #1;
    check("t035_b1", {24'd0, o_dat}, 8'h51);
    @(negedge clk_i);
    in_ready = 1'b0; app_flush = 1'b1;
    #1;
    check("t035_rdy_flush", {31'd0, o_rdy}, 0);
    @(negedge clk_i);
    app_flush = 1'b0;
    #1;
    check("t035_lvl_deferred", {24'd0, o_lvl}, 6);
    check("t035_b2", {24'd0, o_dat}, 8'h52);
    in_req = 1'b0;
    @(negedge clk_i);
    out_ready = 1'b1; in_ack = 1'b1;
    @(negedge clk_i);
    out_ready = 1'b0; in_ack = 1'b0;
    #1;
    check("t035_lvl0", {24'd0, o_lvl}, 0);
    check("t035_empty", {31'd0, o_empty}, 1);
    app_write(8'h60);
    q = {8'h60};
    do_txn(q, 0, 1, "t035post");

    // Flush in IDLE applies at the next edge.
    app_write(8'h70); app_write(8'h71);
    @(negedge clk_i);
    app_flush = 1'b1;
    #1;
    check("idle_flush_rdy", {31'd0, o_rdy}, 0);
    @(negedge clk_i);
    app_flush = 1'b0;
    #1;
    check("idle_flush_lvl", {24'd0, o_lvl}, 0);
    check("idle_flush_empty", {31'd0, o_empty}, 1);
    qe.delete();
    do_txn(qe, 0, 0, "idle_flush_txn");

    // Reset in the middle of a transaction drops everything.
    app_write(8'h80); app_write(8'h81); app_write(8'h82);
    @(negedge clk_i);
    in_req = 1'b1; in_ready = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b0; in_req = 1'b0; in_ready = 1'b0;
    #1;
    check("midrst_lvl", {24'd0, o_lvl}, 0);
    check("midrst_empty", {31'd0, o_empty}, 1);
    check("midrst_vld", {31'd0, o_vld}, 0);
    check("midrst_dat", {24'd0, o_dat}, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // 12-byte buffer: 30 write/ACK rounds wrapping the pointers.
    sel = 1'b1;
    seqb = 8'h00;
    zlp = 0;
    mq.delete();
    for (int i = 0; i < 30; i++) begin
      n = 3 + (i % 6);
      for (int k = 0; k < n; k++) begin
        if (mq.size() < 12) begin
          app_write(seqb);
          mq.push_back(seqb);
          seqb = seqb + 8'd1;
        end
      end
      @(negedge clk_i); #1;
      check("t036_lvl", {24'd0, o_lvl}, mq.size());
      check("t036_le12", (o_lvl <= 8'd12) ? 1 : 0, 1);
      q.delete();
      if (zlp == 0)
        for (int j = 0; j < mq.size() && j < 8; j++) q.push_back(mq[j]);
      do_txn(q, 0, mq.size(), "t036");
      sent = q.size();
      for (int j = 0; j < sent; j++) void'(mq.pop_front());
      if (sent == 8 && mq.size() == 0) zlp = 1;
      else if (sent == 0)              zlp = 0;
    end
    @(negedge clk_i); #1;
    check("t036_final_lvl", {24'd0, o_lvl}, mq.size());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/in_pkt_fifo.md
IN_PKT_FIFO -- requirements
Module: in_pkt_fifo

Interface
REQ-001 SHALL have parameter IN_MAXPACKETSIZE, default 8: maximum bytes per IN packet, range 1..64.
REQ-002 SHALL have parameter IN_BUFFER_SIZE, default 16: byte capacity, range IN_MAXPACKETSIZE..256, independent of packet size.
REQ-003 SHALL have parameter BIT_SAMPLES, default 4: clk_i cycles per application byte slot.
REQ-004 SHALL have parameter ZLP_EN, default 1: 1 = zero-length packet (ZLP) terminates a run of full-size packets.
REQ-005 SHALL have port clk_i, input, 1: single clock, 12MHz*BIT_SAMPLES; all logic in this domain.
REQ-006 SHALL have port rstn_i, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports app_in_data_i (input, 8), app_in_valid_i (input, 1), app_in_ready_o (output, 1): application byte handshake.
REQ-008 SHALL have port app_flush_i, input, 1: discard all buffered bytes.
REQ-009 SHALL have ports in_empty_o (output, 1), in_full_o (output, 1), in_level_o (output, ceil_log2(IN_BUFFER_SIZE+1)): committed occupancy.
REQ-010 SHALL have ports in_data_o (output, 8), in_valid_o (output, 1): byte to SIE.
REQ-011 SHALL have inputs in_req_i, in_ready_i, in_data_ack_i, out_valid_i, out_ready_i, each 1 bit: SIE transaction controls.

Function
REQ-012 Pointers: committed read first_q, speculative read rd_q, write last_q; each wraps IN_BUFFER_SIZE-1 -> 0 (non-power-of-2 sizes included).
REQ-013 level_q SHALL count committed bytes; in_empty_o = (level_q==0); in_full_o = (level_q==IN_BUFFER_SIZE).
REQ-014 app_in_ready_o = ~in_full_o AND pacing counter == BIT_SAMPLES-1; byte written at last_q on valid&ready; counter restarts at 0 after each write.
REQ-015 States: IDLE, DATA, WAIT_ACK.
REQ-016 IDLE: in_req_i rising edge -> DATA; rd_q <= first_q; sent_q <= 0.
REQ-017 DATA: in_valid_o = 1 iff rd_q != last_q AND sent_q < IN_MAXPACKETSIZE AND zlp_pend_q == 0; in_data_o = buffer[rd_q].
REQ-018 DATA: in_valid_o & in_ready_i -> rd_q advances (wrap), sent_q++; in_valid_o reflects new state next cycle.
REQ-019 DATA: in_req_i low -> WAIT_ACK.
REQ-020 WAIT_ACK: out_ready_i & in_data_ack_i -> commit: first_q <= rd_q, level_q -= sent_q, IDLE.
REQ-021 WAIT_ACK: out_valid_i, or out_ready_i without in_data_ack_i -> IDLE without commit; next transaction retransmits same bytes.
REQ-022 WAIT_ACK: in_req_i rising edge -> DATA as in REQ-016 (retry, no commit).
REQ-023 ZLP: with ZLP_EN=1, commit with sent_q==IN_MAXPACKETSIZE leaving level_q==0 sets zlp_pend_q; committed ZLP (sent_q==0) clears it; ZLP_EN=0 ties zlp_pend_q to 0.
REQ-024 Same-cycle write and commit: level_q <= level_q + 1 - sent_q; in_full_o evaluated on current level_q.
REQ-025 app_flush_i in IDLE: next edge first_q=rd_q=last_q, level_q=0, zlp_pend_q=0; app write that cycle dropped (app_in_ready_o low while flush high).
REQ-026 app_flush_i in DATA/WAIT_ACK: latched; applied on entry to IDLE, after any commit.
REQ-027 Speculative reads SHALL NOT free space; in_full_o depends on committed level only.

Reset
REQ-028 rstn_i low SHALL asynchronously force IDLE, all pointers/level_q/sent_q/pacing counter/zlp_pend_q/flush latch to 0, buffer contents to 0.
REQ-029 During reset: in_valid_o=0, app_in_ready_o=0, in_empty_o=1, in_full_o=0, in_level_o=0, in_data_o=0.
REQ-030 Reset mid-transaction SHALL drop all uncommitted and committed data; no partial commit.

Verification
REQ-031 Write 3 bytes 0xA1,0xA2,0xA3; request, ready every cycle, ACK -> 3 bytes in order, in_valid_o low after 3rd, level 3->0, in_empty_o=1.
REQ-032 Write 20 bytes (defaults); 3 ACKed transactions -> packets of 8,8,4 bytes; in_full_o=1 at 16 until first ACK.
REQ-033 Write 5 bytes; transaction ended by out_valid_i (no ACK) -> level stays 5; next transaction resends same 5 bytes; ACK -> level 0.
REQ-034 Write exactly 8 bytes, ACK; write 2 more, request -> in_valid_o stays low (ZLP), ACK; next request sends the 2 bytes.
REQ-035 Write 6 bytes; app_flush_i during DATA after 2 bytes sent -> flush deferred; after ACK/IDLE level=0, in_empty_o=1.
REQ-036 IN_BUFFER_SIZE=12: 30 write/ACK cycles -> pointers wrap 11->0, data order preserved, level never exceeds 12.
